// File: rtl/card_game_pkg.sv
// Shared types and constants for the 6x6 memory-match game controller.
package card_game_pkg;

  localparam int unsigned GRID_DIM  = 6;
  localparam int unsigned NUM_CELLS = 36;
  localparam int unsigned NUM_PAIRS = 18;

  typedef logic [5:0] loc_t;

  typedef enum logic [2:0] {
    PICK1,
    PICK2,
    RD1,
    RD2,
    CMP,
    SHOW,
    DONE
  } game_state_t;

  function automatic loc_t to_loc(input logic [2:0] row, input logic [2:0] col);
    return loc_t'(row) * loc_t'(GRID_DIM) + loc_t'(col);
  endfunction

endpackage

// File: rtl/grid_cursor.sv
// Board cursor: row/col registers with per-axis wrap and single-action button priority.
module grid_cursor
  import card_game_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_move_en,
  input  logic       i_home,
  input  logic       i_select,
  input  logic       i_up,
  input  logic       i_down,
  input  logic       i_left,
  input  logic       i_right,
  output logic [5:0] o_loc
);

  localparam logic [2:0] LastIdx = 3'(GRID_DIM - 1);

  logic [2:0] r_row;
  logic [2:0] r_col;
  logic [2:0] w_row_nxt;
  logic [2:0] w_col_nxt;

  // A select pulse is the whole action for its cycle, so it masks any move.
  always_comb begin
    w_row_nxt = r_row;
    w_col_nxt = r_col;
    if (i_home) begin
      w_row_nxt = '0;
      w_col_nxt = '0;
    end else if (i_move_en && !i_select) begin
      if (i_up) begin
        w_row_nxt = (r_row == '0) ? LastIdx : r_row - 3'd1;
      end else if (i_down) begin
        w_row_nxt = (r_row == LastIdx) ? '0 : r_row + 3'd1;
      end else if (i_left) begin
        w_col_nxt = (r_col == '0) ? LastIdx : r_col - 3'd1;
      end else if (i_right) begin
        w_col_nxt = (r_col == LastIdx) ? '0 : r_col + 3'd1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_row <= '0;
      r_col <= '0;
    end else begin
      r_row <= w_row_nxt;
      r_col <= w_col_nxt;
    end
  end

  assign o_loc = to_loc(r_row, r_col);

endmodule

// File: rtl/card_match_ctrl.sv
// Memory-match game controller: cursor, two-card pick/compare turn, score and display feed.
module card_match_ctrl
  import card_game_pkg::*;
#(
  parameter int unsigned VAL_W       = 5,
  parameter int unsigned SHOW_CYCLES = 50_000_000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_select,
  output logic [5:0]       rd_addr,
  input  logic [VAL_W-1:0] rd_data,
  output logic [5:0]       scan_addr,
  output logic [5:0]       selected_card,
  output logic [5:0]       card1,
  output logic [5:0]       card2,
  output logic             found_valid,
  output logic [35:0]      found_map,
  output logic [35:0]      shown_map,
  output logic [4:0]       match_count,
  output logic [CNT_W-1:0] miss_count,
  output logic             game_over
);

  localparam int unsigned TmrW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  game_state_t      r_state;
  game_state_t      w_state_nxt;

  logic [5:0]       r_scan;
  logic [5:0]       r_first;
  logic [5:0]       r_second;
  logic [5:0]       r_rd_addr;
  logic [VAL_W-1:0] r_val1;
  logic [5:0]       r_card1;
  logic [5:0]       r_card2;
  logic             r_found_valid;
  logic [35:0]      r_found_map;
  logic [35:0]      r_shown_map;
  logic [4:0]       r_match_cnt;
  logic [CNT_W-1:0] r_miss_cnt;
  logic [TmrW-1:0]  r_timer;

  logic [5:0]       w_cursor;
  logic             w_cur_free;
  logic             w_vals_equal;
  logic             w_move_en;
  logic             w_home;
  logic             w_pick1_ok;
  logic             w_pick2_ok;
  logic             w_match;
  logic             w_miss;
  logic             w_show_done;
  logic             w_game_over;

  grid_cursor u_cursor (
    .i_clk     (clock),
    .i_rst     (reset),
    .i_move_en (w_move_en),
    .i_home    (w_home),
    .i_select  (btn_select),
    .i_up      (btn_up),
    .i_down    (btn_down),
    .i_left    (btn_left),
    .i_right   (btn_right),
    .o_loc     (w_cursor)
  );

  assign w_cur_free   = !r_found_map[w_cursor];
  assign w_vals_equal = (rd_data == r_val1);

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= PICK1;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PICK1: if (btn_select && w_cur_free) w_state_nxt = PICK2;
      PICK2: if (btn_select && w_cur_free && (w_cursor != r_first)) w_state_nxt = RD1;
      RD1:   w_state_nxt = RD2;
      RD2:   w_state_nxt = CMP;
      CMP: begin
        if (!w_vals_equal) begin
          w_state_nxt = SHOW;
        end else if (r_match_cnt == 5'(NUM_PAIRS - 1)) begin
          w_state_nxt = DONE;
        end else begin
          w_state_nxt = PICK1;
        end
      end
      SHOW:    if (r_timer == '0) w_state_nxt = PICK1;
      DONE:    if (btn_select) w_state_nxt = PICK1;
      default: w_state_nxt = PICK1;
    endcase
  end

  // Per-state decode driving the datapath and cursor
  always_comb begin
    w_move_en   = 1'b0;
    w_home      = 1'b0;
    w_pick1_ok  = 1'b0;
    w_pick2_ok  = 1'b0;
    w_match     = 1'b0;
    w_miss      = 1'b0;
    w_show_done = 1'b0;
    w_game_over = 1'b0;
    case (r_state)
      PICK1: begin
        w_move_en  = 1'b1;
        w_pick1_ok = btn_select && w_cur_free;
      end
      PICK2: begin
        w_move_en  = 1'b1;
        w_pick2_ok = btn_select && w_cur_free && (w_cursor != r_first);
      end
      CMP: begin
        w_match = w_vals_equal;
        w_miss  = !w_vals_equal;
      end
      SHOW: begin
        w_move_en   = 1'b1;
        w_show_done = (r_timer == '0);
      end
      DONE: begin
        w_game_over = 1'b1;
        w_home      = btn_select;
      end
      default: ;
    endcase
  end

  // Turn datapath: picks, memory reads, scoring and the miss display timer
  always_ff @(posedge clock) begin
    if (reset) begin
      r_scan        <= '0;
      r_first       <= '0;
      r_second      <= '0;
      r_rd_addr     <= '0;
      r_val1        <= '0;
      r_card1       <= '0;
      r_card2       <= '0;
      r_found_valid <= 1'b0;
      r_found_map   <= '0;
      r_shown_map   <= '0;
      r_match_cnt   <= '0;
      r_miss_cnt    <= '0;
      r_timer       <= '0;
    end else begin
      r_scan        <= (r_scan == 6'(NUM_CELLS - 1)) ? '0 : r_scan + 6'd1;
      r_found_valid <= 1'b0;

      if (w_pick1_ok) begin
        r_first                <= w_cursor;
        r_shown_map[w_cursor]  <= 1'b1;
      end

      // First address goes out now so its data lands in RD2.
      if (w_pick2_ok) begin
        r_second               <= w_cursor;
        r_shown_map[w_cursor]  <= 1'b1;
        r_rd_addr              <= r_first;
      end

      if (r_state == RD1) begin
        r_rd_addr <= r_second;
      end

      if (r_state == RD2) begin
        r_val1 <= rd_data;
      end

      if (w_match) begin
        r_card1                <= r_first;
        r_card2                <= r_second;
        r_found_valid          <= 1'b1;
        r_found_map[r_first]   <= 1'b1;
        r_found_map[r_second]  <= 1'b1;
        r_shown_map[r_first]   <= 1'b0;
        r_shown_map[r_second]  <= 1'b0;
        r_match_cnt            <= r_match_cnt + 5'd1;
      end

      if (w_miss) begin
        if (r_miss_cnt != '1) begin
          r_miss_cnt <= r_miss_cnt + 1'b1;
        end
        r_timer <= TmrW'(SHOW_CYCLES - 1);
      end

      if (r_state == SHOW) begin
        if (w_show_done) begin
          r_shown_map[r_first]  <= 1'b0;
          r_shown_map[r_second] <= 1'b0;
        end else begin
          r_timer <= r_timer - 1'b1;
        end
      end

      if (w_home) begin
        r_found_map <= '0;
        r_shown_map <= '0;
        r_match_cnt <= '0;
        r_miss_cnt  <= '0;
      end
    end
  end

  assign rd_addr       = r_rd_addr;
  assign scan_addr     = r_scan;
  assign selected_card = w_cursor;
  assign card1         = r_card1;
  assign card2         = r_card2;
  assign found_valid   = r_found_valid;
  assign found_map     = r_found_map;
  assign shown_map     = r_shown_map;
  assign match_count   = r_match_cnt;
  assign miss_count    = r_miss_cnt;
  assign game_over     = w_game_over;

endmodule

// File: tb/tb_card_match_ctrl.sv
// Directed bench for card_match_ctrl with a one-cycle-latency board memory model.
module tb_card_match_ctrl;

  localparam int unsigned ShowCycles = 10;
  localparam int BtnSel   = 0;
  localparam int BtnUp    = 1;
  localparam int BtnDown  = 2;
  localparam int BtnLeft  = 3;
  localparam int BtnRight = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        btn_up = 1'b0;
  logic        btn_down = 1'b0;
  logic        btn_left = 1'b0;
  logic        btn_right = 1'b0;
  logic        btn_select = 1'b0;
  logic [5:0]  rd_addr;
  logic [4:0]  rd_data;
  logic [5:0]  scan_addr;
  logic [5:0]  selected_card;
  logic [5:0]  card1;
  logic [5:0]  card2;
  logic        found_valid;
  logic [35:0] found_map;
  logic [35:0] shown_map;
  logic [4:0]  match_count;
  logic [7:0]  miss_count;
  logic        game_over;

  logic [4:0]  mem [36];

  int n_checks = 0;
  int n_errors = 0;
  int exp_row  = 0;
  int exp_col  = 0;

  card_match_ctrl #(
    .VAL_W       (5),
    .SHOW_CYCLES (ShowCycles),
    .CNT_W       (8)
  ) u_dut (
    .clock         (clock),
    .reset         (reset),
    .btn_up        (btn_up),
    .btn_down      (btn_down),
    .btn_left      (btn_left),
    .btn_right     (btn_right),
    .btn_select    (btn_select),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .scan_addr     (scan_addr),
    .selected_card (selected_card),
    .card1         (card1),
    .card2         (card2),
    .found_valid   (found_valid),
    .found_map     (found_map),
    .shown_map     (shown_map),
    .match_count   (match_count),
    .miss_count    (miss_count),
    .game_over     (game_over)
  );

  always #5 clock = ~clock;

  always_ff @(posedge clock) rd_data <= mem[rd_addr];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic press(input int code);
    btn_select = (code == BtnSel);
    btn_up     = (code == BtnUp);
    btn_down   = (code == BtnDown);
    btn_left   = (code == BtnLeft);
    btn_right  = (code == BtnRight);
    tick(1);
    btn_select = 1'b0;
    btn_up     = 1'b0;
    btn_down   = 1'b0;
    btn_left   = 1'b0;
    btn_right  = 1'b0;
  endtask

  task automatic goto_loc(input int loc);
    while (exp_row != loc / 6) begin
      press(BtnDown);
      exp_row = (exp_row + 1) % 6;
    end
    while (exp_col != loc % 6) begin
      press(BtnRight);
      exp_col = (exp_col + 1) % 6;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    exp_row = 0;
    exp_col = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 36; i++) mem[i] = 5'd31;
    mem[3]  = 5'd7;
    mem[17] = 5'd7;
    mem[0]  = 5'd1;
    mem[1]  = 5'd2;

    // Reset values, then free-running scan address
    reset = 1'b1;
    tick(2);
    check("rst_scan", scan_addr, 0);
    check("rst_sel", selected_card, 0);
    check("rst_found", found_map, 0);
    check("rst_shown", shown_map, 0);
    check("rst_match", match_count, 0);
    check("rst_miss", miss_count, 0);
    check("rst_fv", found_valid, 0);
    check("rst_over", game_over, 0);
    check("rst_card1", card1, 0);
    check("rst_rdaddr", rd_addr, 0);
    reset = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      tick(1);
      check("scan", scan_addr, 64'(k % 36));
    end
    check("idle_sel", selected_card, 0);
    check("idle_found", found_map, 0);
    check("idle_match", match_count, 0);

    // Cursor wrap and priority
    press(BtnLeft);  exp_col = 5;
    check("wrap_left", selected_card, 5);
    press(BtnUp);    exp_row = 5;
    check("wrap_up", selected_card, 35);
    press(BtnRight); exp_col = 0;
    check("wrap_right", selected_card, 30);
    btn_up = 1'b1; btn_left = 1'b1;
    tick(1);
    btn_up = 1'b0; btn_left = 1'b0;
    exp_row = 4;
    check("prio_up_left", selected_card, 24);
    btn_select = 1'b1; btn_down = 1'b1;
    tick(1);
    btn_select = 1'b0; btn_down = 1'b0;
    check("prio_sel_pos", selected_card, 24);
    check("prio_sel_shown", shown_map, 64'd1 << 24);
    do_reset();

    // Matching pair: 3 and 17
    goto_loc(3);
    press(BtnSel);
    check("m_shown1", shown_map, 64'd1 << 3);
    goto_loc(17);
    check("m_sel17", selected_card, 17);
    press(BtnSel);
    check("m_shown2", shown_map, (64'd1 << 3) | (64'd1 << 17));
    check("m_fv_rd1", found_valid, 0);
    tick(1);
    check("m_fv_rd2", found_valid, 0);
    tick(1);
    check("m_fv_cmp", found_valid, 0);
    tick(1);
    check("m_fv", found_valid, 1);
    check("m_card1", card1, 3);
    check("m_card2", card2, 17);
    check("m_found", found_map, (64'd1 << 3) | (64'd1 << 17));
    check("m_match", match_count, 1);
    check("m_shown_clr", shown_map, 0);
    tick(1);
    check("m_fv_drop", found_valid, 0);
    check("m_card1_hold", card1, 3);

    // Miss: 0 and 1, shown for SHOW_CYCLES, select ignored meanwhile
    goto_loc(0);
    press(BtnSel);
    goto_loc(1);
    press(BtnSel);
    tick(3);
    check("x_miss", miss_count, 1);
    check("x_shown", shown_map, 64'h3);
    for (int k = 1; k <= 9; k++) begin
      if (k == 4) press(BtnSel);
      else tick(1);
      check("x_shown_hold", shown_map, 64'h3);
    end
    tick(1);
    check("x_shown_clr", shown_map, 0);
    check("x_miss_after", miss_count, 1);
    check("x_match_after", match_count, 1);

    // Illegal picks: found location in PICK1, repeat location and found location in PICK2
    goto_loc(3);
    press(BtnSel);
    check("i_found_pick", shown_map, 0);
    goto_loc(1);
    press(BtnSel);
    check("i_pick1", shown_map, 64'h2);
    press(BtnSel);
    tick(4);
    check("i_same_shown", shown_map, 64'h2);
    check("i_same_miss", miss_count, 1);
    check("i_same_match", match_count, 1);
    goto_loc(3);
    press(BtnSel);
    tick(4);
    check("i_found2_miss", miss_count, 1);
    check("i_found2_match", match_count, 1);

    // Full game: pairs are (p, p+18)
    do_reset();
    for (int i = 0; i < 36; i++) mem[i] = 5'(i % 18);
    goto_loc(0);
    press(BtnSel);
    goto_loc(1);
    press(BtnSel);
    tick(13);
    check("g_miss", miss_count, 1);
    check("g_shown", shown_map, 0);
    for (int p = 0; p < 18; p++) begin
      goto_loc(p);
      press(BtnSel);
      goto_loc(p + 18);
      press(BtnSel);
      tick(3);
      check("g_fv", found_valid, 1);
      check("g_card1", card1, 64'(p));
      check("g_card2", card2, 64'(p + 18));
      check("g_match", match_count, 64'(p + 1));
    end
    check("g_over", game_over, 1);
    check("g_found_all", found_map, 64'hF_FFFF_FFFF);
    check("g_shown_none", shown_map, 0);
    tick(1);
    check("g_fv_drop", found_valid, 0);
    check("g_over_hold", game_over, 1);
    press(BtnLeft);
    check("d_left_ign", selected_card, 35);
    press(BtnUp);
    check("d_up_ign", selected_card, 35);
    press(BtnSel);
    exp_row = 0;
    exp_col = 0;
    check("d_found_clr", found_map, 0);
    check("d_match_clr", match_count, 0);
    check("d_miss_clr", miss_count, 0);
    check("d_over_clr", game_over, 0);
    check("d_sel_home", selected_card, 0);
    check("d_card1_hold", card1, 17);
    check("d_card2_hold", card2, 35);
    press(BtnSel);
    check("d_pick1", shown_map, 64'h1);

    // Reset during CMP aborts the turn
    goto_loc(18);
    press(BtnSel);
    tick(2);
    reset = 1'b1;
    tick(1);
    check("r_fv", found_valid, 0);
    check("r_found", found_map, 0);
    check("r_shown", shown_map, 0);
    check("r_sel", selected_card, 0);
    check("r_scan", scan_addr, 0);
    check("r_card1", card1, 0);
    check("r_match", match_count, 0);
    reset = 1'b0;
    exp_row = 0;
    exp_col = 0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("r_fv_after", found_valid, 0);
    end
    check("r_match_after", match_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
